// File: rtl/data_mem_responder_pkg.sv
// Shared constants, responder state encoding and the request legality helper
// for the MEM-stage data-memory responder.
package data_mem_responder_pkg;

    localparam int unsigned RegBus = 32;

    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    // RstEnable is the pipeline's active-high reset level; this block has its
    // own active-low reset input, so its asserted level is kept separate.
    localparam logic RstEnable    = 1'b1;
    localparam logic RstAssertedN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } resp_state_e;

    // A request is illegal when no byte lane is selected or when any address
    // bit above the word index plus byte offset is set.
    function automatic logic req_illegal(input logic [31:0] addr,
                                         input logic [3:0]  sel,
                                         input int unsigned aw);
        logic [31:0] hi_mask;
        hi_mask = 32'hFFFF_FFFF << (aw + 2);
        return (sel == 4'b0000) || ((addr & hi_mask) != 32'h0);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the responder
// (slave). Signal names carry the responder's point of view.
//   ce_i, we_i, addr_i, sel_i, data_i : request from MEM stage
//   data_o, stall_req_o, err_o        : response to MEM stage / controller
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic              ce_i;
    logic              we_i;
    logic [31:0]       addr_i;
    logic [3:0]        sel_i;
    logic [RegBus-1:0] data_i;
    logic [RegBus-1:0] data_o;
    logic              stall_req_o;
    logic              err_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o, stall_req_o, err_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o, stall_req_o, err_o
    );

endinterface

// File: rtl/byte_lane_ram.sv
// Word-organised storage with per-byte write enables.
//   clk      : write clock
//   raddr_i  : read word index, rdata_o follows combinationally
//   waddr_i  : write word index
//   wbe_i    : byte write enables, bit n covers wdata_i[8n+7:8n]
//   wdata_i  : write data
// Contents are never reset.
module byte_lane_ram #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [31:0]           rdata_o,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [3:0]            wbe_i,
    input  logic [31:0]           wdata_i
);

    logic [31:0] mem_q [2**ADDR_WIDTH];

    assign rdata_o = mem_q[raddr_i];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wbe_i[i]) begin
                mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Slave end of the MEM-stage data-memory interface. Performs word/byte
// accesses against on-chip storage after WAIT_STATES stall cycles and holds
// the pipeline via stall_req_o until the access completes.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : slave modport (ce/we/addr/sel/data in, data/stall_req/err out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; legality check, request acceptance
// WAIT    | request latched, counting down wait states, stall asserted
// DONE    | access finished, read result on data_o, stall released
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam bit         ZeroWait = (WAIT_STATES == 0);
    localparam logic [3:0] WaitLoad = ZeroWait ? 4'd0 : 4'(WAIT_STATES - 1);

    resp_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic [3:0]            sel_q, sel_d;
    logic [RegBus-1:0]     wdata_q, wdata_d;
    logic [RegBus-1:0]     data_q, data_d;
    logic                  err_q, err_d;

    logic                  rst_ok;
    logic                  req_bad;
    logic                  req_ok;
    logic [ADDR_WIDTH-1:0] word_in;

    logic                  stall_req;
    logic [RegBus-1:0]     rdata_out;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [3:0]            ram_wbe;
    logic [RegBus-1:0]     ram_wdata;
    logic [RegBus-1:0]     ram_rdata;

    assign rst_ok  = (rst != RstAssertedN);
    assign req_bad = (bus.ce_i == ChipEnable) &&  req_illegal(bus.addr_i, bus.sel_i, ADDR_WIDTH);
    assign req_ok  = (bus.ce_i == ChipEnable) && !req_illegal(bus.addr_i, bus.sel_i, ADDR_WIDTH);
    assign word_in = bus.addr_i[ADDR_WIDTH+1:2];

    byte_lane_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata),
        .waddr_i (ram_waddr),
        .wbe_i   (ram_wbe),
        .wdata_i (ram_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstAssertedN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= WriteDisable;
            word_q  <= '0;
            sel_q   <= 4'b0000;
            wdata_q <= ZeroWord;
            data_q  <= ZeroWord;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        word_d  = word_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_bad) begin
                    err_d  = 1'b1;
                    data_d = ZeroWord;
                end else if (req_ok && !ZeroWait) begin
                    state_d = ST_WAIT;
                    cnt_d   = WaitLoad;
                    we_d    = bus.we_i;
                    word_d  = word_in;
                    sel_d   = bus.sel_i;
                    wdata_d = bus.data_i;
                end
            end
            ST_WAIT: begin
                // Dropping ce_i is a pipeline flush: abandon without access.
                if (bus.ce_i == ChipDisable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    data_d  = (we_q == WriteEnable) ? ZeroWord : ram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall covers the accepting IDLE cycle and every WAIT cycle; all
    // outputs and storage writes are forced quiet while reset is held.
    always_comb begin
        stall_req = 1'b0;
        rdata_out = data_q;
        ram_raddr = word_q;
        ram_waddr = word_q;
        ram_wbe   = 4'b0000;
        ram_wdata = wdata_q;
        if (ZeroWait) begin
            ram_raddr = word_in;
            ram_waddr = word_in;
            ram_wdata = bus.data_i;
            if (req_ok && bus.we_i == WriteEnable) begin
                ram_wbe = bus.sel_i;
            end
            rdata_out = (req_ok && bus.we_i == WriteDisable) ? ram_rdata : ZeroWord;
        end else begin
            case (state_q)
                ST_IDLE: stall_req = req_ok;
                ST_WAIT: begin
                    stall_req = (bus.ce_i == ChipEnable);
                    if (bus.ce_i == ChipEnable && cnt_q == 4'd0 && we_q == WriteEnable) begin
                        ram_wbe = sel_q;
                    end
                end
                default: stall_req = 1'b0;
            endcase
        end
        if (!rst_ok) begin
            stall_req = 1'b0;
            ram_wbe   = 4'b0000;
            rdata_out = ZeroWord;
        end
    end

    assign bus.stall_req_o = stall_req;
    assign bus.data_o      = rdata_out;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int unsigned AW = 10;
    localparam int          WS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus2();
    data_mem_responder_if bus0();

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) u_ws2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );
    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Expected outputs, set by the stimulus for the cycle being driven.
    logic        exp2_stall = 1'b0;
    logic        exp2_err   = 1'b0;
    logic [31:0] exp2_data  = 32'h0;
    logic        exp0_err   = 1'b0;
    logic [31:0] exp0_data  = 32'h0;

    // Behavioural model state.
    logic [31:0] mem2 [int];
    logic [31:0] mem0 [int];
    logic [31:0] held2 = 32'h0;
    logic        pend0 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ws2_stall", 32'(bus2.stall_req_o), 32'(exp2_stall));
            check("ws2_err",   32'(bus2.err_o),       32'(exp2_err));
            check("ws2_data",  bus2.data_o,           exp2_data);
            check("ws0_stall", 32'(bus0.stall_req_o), 32'h0);
            check("ws0_err",   32'(bus0.err_o),       32'(exp0_err));
            check("ws0_data",  bus0.data_o,           exp0_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic legal(input logic [31:0] a, input logic [3:0] s);
        return (s != 4'b0000) && (a < (32'h1 << (AW + 2)));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the wait-state instance. abort_k selects the WAIT
    // cycle (0-based) in which ce_i is dropped; -1 runs to completion.
    task automatic acc2(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int abort_k, output logic [31:0] rd);
        logic ok;
        int   wi;
        ok = legal(a, s);
        wi = int'(a >> 2);
        rd = held2;
        bus2.ce_i = 1'b1; bus2.we_i = w; bus2.addr_i = a; bus2.sel_i = s; bus2.data_i = d;
        exp2_stall = ok; exp2_err = 1'b0; exp2_data = held2;
        step();
        if (!ok) begin
            bus2.ce_i = 1'b0;
            exp2_stall = 1'b0; exp2_err = 1'b1; held2 = 32'h0; exp2_data = 32'h0;
            step();
            exp2_err = 1'b0;
            step();
            rd = held2;
            return;
        end
        for (int k = 0; k < WS; k++) begin
            if (k == abort_k) begin
                bus2.ce_i = 1'b0; exp2_stall = 1'b0;
                step();
                step();
                return;
            end
            // Live inputs wander during WAIT; only the latched copy may count.
            bus2.addr_i = a ^ 32'h0000_0004; bus2.sel_i = ~s; bus2.data_i = ~d;
            bus2.we_i = ~w;
            exp2_stall = 1'b1;
            step();
        end
        if (w) begin
            mem2[wi] = merge(mem2.exists(wi) ? mem2[wi] : 32'h0, d, s);
            held2 = 32'h0;
        end else begin
            held2 = mem2[wi];
        end
        bus2.ce_i = 1'b0; exp2_stall = 1'b0; exp2_data = held2;
        step();
        rd = held2;
        step();
    endtask

    // One cycle on the zero-wait instance; requests may be back to back.
    task automatic acc0(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd);
        logic ok;
        int   wi;
        ok = legal(a, s);
        wi = int'(a >> 2);
        bus0.ce_i = 1'b1; bus0.we_i = w; bus0.addr_i = a; bus0.sel_i = s; bus0.data_i = d;
        exp0_err  = pend0;
        exp0_data = (ok && !w) ? mem0[wi] : 32'h0;
        rd = exp0_data;
        step();
        if (ok && w) mem0[wi] = merge(mem0.exists(wi) ? mem0[wi] : 32'h0, d, s);
        pend0 = !ok;
    endtask

    task automatic idle0();
        bus0.ce_i = 1'b0;
        exp0_err = pend0; exp0_data = 32'h0;
        step();
        pend0 = 1'b0;
        exp0_err = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        bus2.ce_i = 1'b0; bus2.we_i = 1'b0; bus2.addr_i = 32'h0; bus2.sel_i = 4'h0; bus2.data_i = 32'h0;
        bus0.ce_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = 32'h0; bus0.sel_i = 4'h0; bus0.data_i = 32'h0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ws2_stall", 32'(bus2.stall_req_o), 32'h0);
        check("rst_ws2_err",   32'(bus2.err_o),       32'h0);
        check("rst_ws2_data",  bus2.data_o,           32'h0);
        check("rst_ws0_data",  bus0.data_o,           32'h0);
        rst = 1'b1;
        chk_en = 1'b1;
        step();

        // Full-word store then load.
        acc2(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, -1, rd);
        acc2(1'b0, 32'h10, 4'b1111, 32'h0, -1, rd);
        check("t1_word", rd, 32'hDEAD_BEEF);

        // Single byte, lane sel[2] = data[23:16].
        acc2(1'b1, 32'h11, 4'b0100, 32'h5A5A_5A5A, -1, rd);
        acc2(1'b0, 32'h10, 4'b1111, 32'h0, -1, rd);
        check("t2_byte", rd, 32'hDE5A_BEEF);

        // Lower halfword on a freshly rewritten word.
        acc2(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, -1, rd);
        acc2(1'b1, 32'h12, 4'b0011, 32'h1234_1234, -1, rd);
        acc2(1'b0, 32'h10, 4'b1111, 32'h0, -1, rd);
        check("t3_half", rd, 32'hDEAD_1234);

        // Aborts in each WAIT cycle leave the word intact.
        acc2(1'b1, 32'h10, 4'b1111, 32'h0BAD_F00D, 1, rd);
        acc2(1'b1, 32'h10, 4'b1111, 32'h0BAD_F00D, 0, rd);
        acc2(1'b0, 32'h10, 4'b1111, 32'h0, -1, rd);
        check("t4_abort", rd, 32'hDEAD_1234);

        // Illegal: no lanes (no write), then out-of-range address.
        acc2(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, -1, rd);
        acc2(1'b0, 32'h10, 4'b1111, 32'h0, -1, rd);
        check("t5_nosel", rd, 32'hDEAD_1234);
        acc2(1'b0, 32'h0001_0000, 4'b1111, 32'h0, -1, rd);
        check("t5_range", rd, 32'h0);

        // Zero-wait instance: back-to-back write/read, byte merge, illegal.
        acc0(1'b1, 32'h40, 4'b1111, 32'hA5A5_0F0F, rd);
        acc0(1'b0, 32'h40, 4'b1111, 32'h0, rd);
        check("t6_zw_word", rd, 32'hA5A5_0F0F);
        acc0(1'b1, 32'h41, 4'b0100, 32'h7777_7777, rd);
        acc0(1'b0, 32'h40, 4'b1111, 32'h0, rd);
        check("t6_zw_byte", rd, 32'hA577_0F0F);
        acc0(1'b0, 32'h40, 4'b0000, 32'h0, rd);
        idle0();
        idle0();

        // Reset mid-WAIT: outputs drop at once, no partial write.
        acc2(1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D, -1, rd);
        acc2(1'b0, 32'h20, 4'b1111, 32'h0, -1, rd);
        bus2.ce_i = 1'b1; bus2.we_i = 1'b1; bus2.addr_i = 32'h20; bus2.sel_i = 4'b1111;
        bus2.data_i = 32'h1111_1111;
        exp2_stall = 1'b1; exp2_data = held2;
        step();
        chk_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t7_rst_stall", 32'(bus2.stall_req_o), 32'h0);
        check("t7_rst_err",   32'(bus2.err_o),       32'h0);
        check("t7_rst_data",  bus2.data_o,           32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus2.ce_i = 1'b0;
        held2 = 32'h0; exp2_stall = 1'b0; exp2_err = 1'b0; exp2_data = 32'h0;
        chk_en = 1'b1;
        step();
        acc2(1'b0, 32'h20, 4'b1111, 32'h0, -1, rd);
        check("t7_intact", rd, 32'hCAFE_F00D);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
